// File: rtl/sd_loader.sv
// Sudoku puzzle screener: buffers an 81-cell puzzle, checks digit range, blank count and
// row/column/box duplicates, then either replays the puzzle or pulses a reject code.
module sd_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in,
    output logic       out_valid,
    output logic [3:0] out,
    output logic       reject,
    output logic [1:0] reason,
    output logic       busy
);

    localparam logic [6:0] LastCell   = 7'd80;
    localparam logic [6:0] NumCells   = 7'd81;
    localparam logic [6:0] WantBlanks = 7'd15;

    typedef enum logic [1:0] {StIdle, StLoad, StCheck, StSend} state_e;

    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;       // index of the most recently stored cell
    logic [6:0] blank_q, blank_d;
    logic       big_q, big_d;
    logic       dup_q, dup_d;
    logic [3:0] digit_q, digit_d;
    logic [6:0] send_q, send_d;

    logic       out_valid_q, out_valid_d;
    logic [3:0] out_q, out_d;
    logic       reject_q, reject_d;
    logic [1:0] reason_q, reason_d;

    logic [3:0] cells_q [81];
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [6:0] rd_addr;
    logic [3:0] rd_data;
    logic       hit;
    logic       dup_all;
    logic [8:0] row_seen, col_seen, box_seen;

    // Puzzle buffer carries no reset; contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            cells_q[wr_addr] <= in;
        end
    end

    assign rd_addr = (state_q == StSend && send_q <= LastCell) ? send_q : 7'd0;
    assign rd_data = cells_q[rd_addr];

    // A cell repeats digit_q if an earlier cell in the same row, column or box already held it.
    always_comb begin
        row_seen = '0;
        col_seen = '0;
        box_seen = '0;
        hit      = 1'b0;
        for (int i = 0; i < 81; i++) begin
            if (cells_q[i] == digit_q) begin
                if (row_seen[i / 9] || col_seen[i % 9] || box_seen[3 * (i / 27) + (i % 9) / 3]) begin
                    hit = 1'b1;
                end
                row_seen[i / 9]                    = 1'b1;
                col_seen[i % 9]                    = 1'b1;
                box_seen[3 * (i / 27) + (i % 9) / 3] = 1'b1;
            end
        end
    end

    assign dup_all = dup_q | hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blank_d     = blank_q;
        big_d       = big_q;
        dup_d       = dup_q;
        digit_d     = digit_q;
        send_d      = send_q;
        out_valid_d = 1'b0;
        out_d       = 4'd0;
        reject_d    = 1'b0;
        reason_d    = 2'd0;
        wr_en       = 1'b0;
        wr_addr     = cnt_q + 7'd1;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = 7'd0;
                    cnt_d   = 7'd0;
                    blank_d = {6'd0, (in == 4'd0)};
                    big_d   = (in > 4'd9);
                    dup_d   = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Once cell 80 is in, the next cycle leaves for CHECK regardless of in_valid.
                if (cnt_q == LastCell) begin
                    digit_d = 4'd1;
                    state_d = StCheck;
                end else if (in_valid) begin
                    wr_en   = 1'b1;
                    cnt_d   = cnt_q + 7'd1;
                    blank_d = blank_q + {6'd0, (in == 4'd0)};
                    big_d   = big_q | (in > 4'd9);
                end else begin
                    reject_d = 1'b1;
                    reason_d = 2'd0;
                    state_d  = StIdle;
                end
            end
            StCheck: begin
                dup_d = dup_all;
                if (digit_q == 4'd9) begin
                    if (big_q) begin
                        reject_d = 1'b1;
                        reason_d = 2'd1;
                        state_d  = StIdle;
                    end else if (blank_q != WantBlanks) begin
                        reject_d = 1'b1;
                        reason_d = 2'd2;
                        state_d  = StIdle;
                    end else if (dup_all) begin
                        reject_d = 1'b1;
                        reason_d = 2'd3;
                        state_d  = StIdle;
                    end else begin
                        out_valid_d = 1'b1;
                        out_d       = rd_data;
                        send_d      = 7'd1;
                        state_d     = StSend;
                    end
                end else begin
                    digit_d = digit_q + 4'd1;
                end
            end
            StSend: begin
                if (send_q == NumCells) begin
                    state_d = StIdle;
                end else begin
                    out_valid_d = 1'b1;
                    out_d       = rd_data;
                    send_d      = send_q + 7'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 7'd0;
            blank_q     <= 7'd0;
            big_q       <= 1'b0;
            dup_q       <= 1'b0;
            digit_q     <= 4'd0;
            send_q      <= 7'd0;
            out_valid_q <= 1'b0;
            out_q       <= 4'd0;
            reject_q    <= 1'b0;
            reason_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blank_q     <= blank_d;
            big_q       <= big_d;
            dup_q       <= dup_d;
            digit_q     <= digit_d;
            send_q      <= send_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            reject_q    <= reject_d;
            reason_q    <= reason_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign reject    = reject_q;
    assign reason    = reason_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sd_loader.sv
// Directed bench for sd_loader: a grid-level model schedules expected outputs per clock edge
// and one compare process checks every edge against that schedule.
module tb_sd_loader;

    localparam int MaxCyc = 3000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in;
    logic       out_valid;
    logic [3:0] out;
    logic       reject;
    logic [1:0] reason;
    logic       busy;

    always #5 clk = ~clk;

    sd_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in       (in),
        .out_valid(out_valid),
        .out      (out),
        .reject   (reject),
        .reason   (reason),
        .busy     (busy)
    );

    int exp_v  [MaxCyc];
    int exp_o  [MaxCyc];
    int exp_r  [MaxCyc];
    int exp_rs [MaxCyc];
    int exp_b  [MaxCyc];
    int pz     [81];
    int blanks [15] = '{1, 2, 3, 11, 12, 13, 21, 22, 23, 55, 56, 57, 65, 66, 67};

    int cyc    = 0;
    bit chk_en = 1'b0;
    int n_vec  = 0;
    int n_bad  = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    // Edge counter plus per-edge comparison, sampled 1 time unit after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (chk_en && cyc < MaxCyc) begin
                check("out_valid", int'(out_valid), exp_v[cyc]);
                check("out", int'(out), exp_o[cyc]);
                check("reject", int'(reject), exp_r[cyc]);
                check("reason", int'(reason), exp_rs[cyc]);
                check("busy", int'(busy), exp_b[cyc]);
            end
        end
    end

    // Solved grid: shifted rows make every row, column and box a permutation of 1..9.
    task automatic build(input int shift);
        for (int i = 0; i < 81; i++) begin
            int r, c, s;
            r = i / 9;
            c = i % 9;
            s = (r * 3 + r / 3 + c) % 9;
            pz[i] = ((s + shift) % 9) + 1;
        end
        for (int j = 0; j < 15; j++) pz[blanks[j]] = 0;
    endtask

    // Verdict from the grid rules: -1 accept, otherwise the reject reason.
    function automatic int verdict();
        int nb;
        bit big;
        bit dup;
        nb  = 0;
        big = 1'b0;
        dup = 1'b0;
        for (int i = 0; i < 81; i++) begin
            if (pz[i] == 0) nb++;
            if (pz[i] > 9) big = 1'b1;
        end
        for (int d = 1; d <= 9; d++) begin
            int rc [9];
            int cc [9];
            int bc [9];
            for (int u = 0; u < 9; u++) begin
                rc[u] = 0;
                cc[u] = 0;
                bc[u] = 0;
            end
            for (int i = 0; i < 81; i++) begin
                if (pz[i] == d) begin
                    rc[i / 9]++;
                    cc[i % 9]++;
                    bc[3 * ((i / 9) / 3) + (i % 9) / 3]++;
                end
            end
            for (int u = 0; u < 9; u++) begin
                if (rc[u] > 1 || cc[u] > 1 || bc[u] > 1) dup = 1'b1;
            end
        end
        if (big) return 1;
        if (nb != 15) return 2;
        if (dup) return 3;
        return -1;
    endfunction

    // Called at a negedge; returns at a negedge with cyc equal to the edge of the last cell.
    task automatic run_puzzle(input int ncells, input bit garbage, output int e);
        int v;
        v = (ncells == 81) ? verdict() : 0;
        e = 0;
        for (int k = 0; k < ncells; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in       = 4'(pz[k]);
            exp_b[cyc + 1] = 1;
            e = cyc + 1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in       = 4'd0;
        if (ncells < 81) begin
            exp_r[e + 1]  = 1;
            exp_rs[e + 1] = 0;
        end else begin
            if (v < 0) begin
                for (int t = 1; t <= 90; t++) exp_b[e + t] = 1;
                for (int k = 0; k < 81; k++) begin
                    exp_v[e + 10 + k] = 1;
                    exp_o[e + 10 + k] = pz[k];
                end
            end else begin
                for (int t = 1; t <= 9; t++) exp_b[e + t] = 1;
                exp_r[e + 10]  = 1;
                exp_rs[e + 10] = v;
            end
            if (garbage) begin
                for (int g = 0; g < 30; g++) begin
                    in_valid = 1'b1;
                    in       = 4'($urandom_range(0, 15));
                    @(negedge clk);
                end
                in_valid = 1'b0;
                in       = 4'd0;
            end
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; resets on the next edge and drops every expectation from there on.
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in       = 4'd0;
        for (int t = cyc + 1; t < MaxCyc; t++) begin
            exp_v[t]  = 0;
            exp_o[t]  = 0;
            exp_r[t]  = 0;
            exp_rs[t] = 0;
            exp_b[t]  = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int e;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in       = 4'd0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Legal puzzle, with in_valid noise through LOAD tail, CHECK and early SEND.
        build(0);
        check("model_legal", verdict(), -1);
        run_puzzle(81, 1'b1, e);
        check("model_first_cell", exp_o[e + 10], 1);
        wait_until(e + 95);

        // 14 blanks.
        build(0);
        pz[1] = 2;
        check("model_14_blanks", verdict(), 2);
        run_puzzle(81, 1'b0, e);
        wait_until(e + 9);
        check("no_reject_before_e10", int'(reject), 0);
        @(negedge clk);
        check("reject_at_e10", int'(reject), 1);
        check("reason_at_e10", int'(reason), 2);
        wait_until(e + 14);

        // Digit 5 twice in box 4, different rows and columns.
        build(0);
        pz[41] = 5;
        check("model_box_dup", verdict(), 3);
        run_puzzle(81, 1'b0, e);
        wait_until(e + 14);

        // Out-of-range digit outranks a wrong blank count.
        build(0);
        pz[40] = 11;
        pz[80] = 0;
        check("model_big_digit", verdict(), 1);
        run_puzzle(81, 1'b0, e);
        wait_until(e + 14);

        // Truncated after 50 cells, then a legal puzzle straight away.
        build(3);
        run_puzzle(50, 1'b0, e);
        check("model_trunc_pulse", exp_r[e + 1], 1);
        build(3);
        check("model_legal_shift3", verdict(), -1);
        run_puzzle(81, 1'b0, e);
        wait_until(e + 95);

        // Reset when cell 30 would be replayed, then a fresh puzzle.
        build(5);
        run_puzzle(81, 1'b0, e);
        wait_until(e + 39);
        check("send_cell29", int'(out), pz[29]);
        do_reset();
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out", int'(out), 0);
        @(negedge clk);
        build(0);
        run_puzzle(81, 1'b0, e);
        wait_until(e + 10);
        check("post_reset_valid", int'(out_valid), 1);
        check("post_reset_cell0", int'(out), 1);
        wait_until(e + 95);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
